// File: rtl/audio_pkg.sv
// Shared constants and types for the control core and the playback engine.
package audio_pkg;
  localparam int ADDR_W   = 23;
  localparam int SAMPLE_W = 16;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_MEM, STREAM, DRAIN, DONE
  } player_state_t;

  // Control-core operating modes, kept here so both blocks decode the same values.
  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_RECORD = 2'd1;
  localparam logic [1:0] MODE_PLAY   = 2'd2;
  localparam logic [1:0] MODE_ERASE  = 2'd3;
endpackage

// File: rtl/audio_player_if.sv
// Sample-memory read port: request held until a one-cycle valid strobe returns data.
interface audio_player_if;
  import audio_pkg::*;
  logic                o_mem_req;
  logic [ADDR_W-1:0]   o_mem_addr;
  logic                i_mem_valid;
  logic [SAMPLE_W-1:0] i_mem_rdata;

  modport master (output o_mem_req, o_mem_addr, input  i_mem_valid, i_mem_rdata);
  modport slave  (input  o_mem_req, o_mem_addr, output i_mem_valid, i_mem_rdata);
endinterface

// File: rtl/audio_player.sv
// Streams a clip from sample memory to the DAC serializer, one sample per frame,
// with a one-entry prefetch buffer hiding memory latency behind the frame period.
module audio_player
  import audio_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                play_start,
  input  logic [ADDR_W-1:0]   play_select,
  input  logic [ADDR_W-1:0]   play_end,
  input  logic                play_pause,
  input  logic                play_stop,
  output logic                play_done,
  audio_player_if.master      mem,
  input  logic                i_dac_req,
  output logic [SAMPLE_W-1:0] o_dac_data,
  output logic [ADDR_W-1:0]   o_cur_addr,
  output logic                o_underrun
);
  player_state_t       state;
  logic [ADDR_W:0]     next_addr;  // extra bit: end address 2^ADDR_W-1 never wraps
  logic [ADDR_W-1:0]   end_addr, buf_addr;
  logic [SAMPLE_W-1:0] buf_data;
  logic                buf_full, stop_pend, done_pend, abort;

  assign abort = play_stop || stop_pend;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      play_done      <= 1'b0;
      mem.o_mem_req  <= 1'b0;
      mem.o_mem_addr <= '0;
      o_dac_data     <= '0;
      o_cur_addr     <= '0;
      o_underrun     <= 1'b0;
      buf_full       <= 1'b0;
      buf_data       <= '0;
      buf_addr       <= '0;
      next_addr      <= '0;
      end_addr       <= '0;
      stop_pend      <= 1'b0;
      done_pend      <= 1'b0;
    end else begin
      play_done <= 1'b0;
      case (state)
        IDLE: if (play_start) begin
          end_addr   <= play_end;
          next_addr  <= {1'b0, play_select};
          o_underrun <= 1'b0;
          buf_full   <= 1'b0;
          stop_pend  <= 1'b0;
          if (play_select > play_end) begin
            state     <= DONE;
            done_pend <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (play_stop) begin
            o_dac_data <= '0;
            state      <= DONE;
            done_pend  <= 1'b1;
          end else if (play_pause) begin
            o_dac_data <= '0;
          end else begin
            mem.o_mem_req  <= 1'b1;
            mem.o_mem_addr <= next_addr[ADDR_W-1:0];
            state          <= WAIT_MEM;
            if (i_dac_req) begin
              o_dac_data <= '0;
              o_underrun <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (play_stop) stop_pend <= 1'b1;
          if (abort || play_pause) begin
            o_dac_data <= '0;
          end else if (i_dac_req) begin
            o_dac_data <= '0;
            o_underrun <= 1'b1;
          end
          // A stopped read still completes on the bus; its data is dropped.
          if (mem.i_mem_valid) begin
            mem.o_mem_req <= 1'b0;
            if (abort) begin
              stop_pend <= 1'b0;
              state     <= DONE;
              done_pend <= 1'b1;
            end else begin
              buf_data  <= mem.i_mem_rdata;
              buf_addr  <= mem.o_mem_addr;
              buf_full  <= 1'b1;
              next_addr <= next_addr + (ADDR_W+1)'(1);
              state     <= STREAM;
            end
          end
        end
        STREAM: begin
          if (play_stop) begin
            o_dac_data <= '0;
            buf_full   <= 1'b0;
            state      <= DONE;
            done_pend  <= 1'b1;
          end else if (play_pause) begin
            o_dac_data <= '0;
          end else if (i_dac_req && buf_full) begin
            o_dac_data <= buf_data;
            o_cur_addr <= buf_addr;
            buf_full   <= 1'b0;
            state      <= (buf_addr == end_addr) ? DRAIN : FETCH;
          end
        end
        DRAIN: begin
          if (play_stop || (!play_pause && i_dac_req)) begin
            o_dac_data <= '0;
            state      <= DONE;
            done_pend  <= 1'b1;
          end else if (play_pause) begin
            o_dac_data <= '0;
          end
        end
        DONE: begin
          if (done_pend) begin
            play_done <= 1'b1;
            done_pend <= 1'b0;
          end
          if (!play_start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_player.sv
// Directed scoreboard bench: each DAC frame pushes its expected sample, a monitor pops it.
module tb_audio_player;
  import audio_pkg::*;

  logic                i_clk = 1'b0, i_rst_n = 1'b0;
  logic                play_start = 1'b0, play_pause = 1'b0, play_stop = 1'b0, i_dac_req = 1'b0;
  logic [ADDR_W-1:0]   play_select = '0, play_end = '0;
  logic                play_done, o_underrun;
  logic [SAMPLE_W-1:0] o_dac_data;
  logic [ADDR_W-1:0]   o_cur_addr;

  audio_player_if mif();

  audio_player dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .play_start(play_start), .play_select(play_select),
    .play_end(play_end), .play_pause(play_pause), .play_stop(play_stop), .play_done(play_done),
    .mem(mif), .i_dac_req(i_dac_req), .o_dac_data(o_dac_data), .o_cur_addr(o_cur_addr),
    .o_underrun(o_underrun)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, errors = 0, cyc = 0, reads = 0, req_rises = 0;
  int done_cnt = 0, done_cyc = 0, req_fall_cyc = 0, mem_lat = 3;
  logic req_q = 1'b0, req_prev = 1'b0, done_prev = 1'b0;
  logic [SAMPLE_W-1:0] exp_q[$];
  logic [SAMPLE_W-1:0] e;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One DAC frame every 50 cycles; the expected post-frame sample goes to the scoreboard.
  task automatic frame(logic [SAMPLE_W-1:0] exp);
    repeat (49) @(posedge i_clk);
    #1 exp_q.push_back(exp);
    i_dac_req = 1'b1;
    @(posedge i_clk);
    #1 i_dac_req = 1'b0;
  endtask

  // Memory model: data = addr[15:0] + 0x1000, valid mem_lat cycles after the request is seen.
  initial begin
    logic [ADDR_W-1:0] a;
    mif.i_mem_valid = 1'b0;
    mif.i_mem_rdata = '0;
    forever begin
      @(posedge i_clk);
      if (mif.o_mem_req && i_rst_n) begin
        a = mif.o_mem_addr;
        reads++;
        repeat (mem_lat - 1) @(posedge i_clk);
        #1 mif.i_mem_valid = 1'b1;
        mif.i_mem_rdata = a[15:0] + 16'h1000;
        @(posedge i_clk);
        #1 mif.i_mem_valid = 1'b0;
      end
    end
  end

  always @(posedge i_clk) req_q <= i_dac_req;

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst_n) begin
      if (req_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame: unexpected frame, dac_data=%0h", o_dac_data);
        end else begin
          e = exp_q.pop_front();
          chk("dac_data", o_dac_data, e);
        end
      end
      if (mif.o_mem_req && !req_prev) req_rises++;
      if (!mif.o_mem_req && req_prev) req_fall_cyc = cyc;
      if (play_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_one_cycle", done_prev, 0);
      end
    end
    req_prev  = mif.o_mem_req;
    done_prev = play_done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, r0, n;
    // Reset state
    tick(3);
    chk("rst_done", play_done, 0);   chk("rst_req", mif.o_mem_req, 0);
    chk("rst_addr", mif.o_mem_addr, 0); chk("rst_dac", o_dac_data, 0);
    chk("rst_cur", o_cur_addr, 0);   chk("rst_underrun", o_underrun, 0);
    chk("rst_state", int'(dut.state), int'(IDLE));
    i_rst_n = 1'b1;
    tick(1);

    // Basic clip 0x100..0x103
    play_select = 23'h100; play_end = 23'h103; play_start = 1'b1; reads = 0; d0 = done_cnt;
    @(negedge i_clk); chk("lat_req_c0", mif.o_mem_req, 0);
    @(negedge i_clk); chk("lat_req_c1", mif.o_mem_req, 0);
    @(negedge i_clk); chk("lat_req_c2", mif.o_mem_req, 1);
    chk("first_addr", mif.o_mem_addr, 23'h100);
    frame(16'h1100); frame(16'h1101); frame(16'h1102); frame(16'h1103);
    frame(16'h0000);
    tick(3);
    chk("basic_done", done_cnt - d0, 1); chk("basic_underrun", o_underrun, 0);
    chk("basic_reads", reads, 4);
    play_start = 1'b0; tick(2);

    // Empty clip: select > end
    play_select = 23'h200; play_end = 23'h1FF; play_start = 1'b1; reads = 0; r0 = req_rises;
    @(negedge i_clk); chk("empty_done_c0", play_done, 0);
    @(negedge i_clk); chk("empty_done_c1", play_done, 0);
    @(negedge i_clk); chk("empty_done_c2", play_done, 1);
    tick(5);
    chk("empty_no_req", req_rises - r0, 0); chk("empty_reads", reads, 0);
    play_start = 1'b0; tick(2);

    // Single-sample clip, start held through DONE, then retrigger
    play_select = 23'h200; play_end = 23'h200; play_start = 1'b1; reads = 0; d0 = done_cnt;
    frame(16'h1200); frame(16'h0000); frame(16'h0000);
    chk("single_reads", reads, 1); chk("single_done", done_cnt - d0, 1);
    play_start = 1'b0; tick(2); play_start = 1'b1;
    frame(16'h1200); frame(16'h0000);
    tick(2);
    chk("retrig_reads", reads, 2); chk("retrig_done", done_cnt - d0, 2);
    play_start = 1'b0; tick(2);

    // Underrun: memory slower than the frame period
    mem_lat = 80;
    play_select = 23'h300; play_end = 23'h301; play_start = 1'b1; reads = 0; d0 = done_cnt;
    frame(16'h0000);
    chk("underrun_set", o_underrun, 1);
    frame(16'h1300); frame(16'h0000); frame(16'h1301); frame(16'h0000);
    tick(2);
    chk("underrun_done", done_cnt - d0, 1); chk("underrun_reads", reads, 2);
    chk("underrun_sticky", o_underrun, 1);
    play_start = 1'b0; tick(2);

    // Pause for 3 frames after the 2nd sample
    mem_lat = 3;
    play_select = 23'h400; play_end = 23'h404; play_start = 1'b1; reads = 0; d0 = done_cnt;
    frame(16'h1400);
    chk("underrun_cleared", o_underrun, 0);
    frame(16'h1401);
    play_pause = 1'b1;
    frame(16'h0000);
    chk("pause_cur_held", o_cur_addr, 23'h401); chk("pause_no_fetch", mif.o_mem_req, 0);
    frame(16'h0000); frame(16'h0000);
    play_pause = 1'b0;
    frame(16'h1402); frame(16'h1403); frame(16'h1404); frame(16'h0000);
    tick(2);
    chk("pause_done", done_cnt - d0, 1); chk("pause_reads", reads, 5);
    play_start = 1'b0; tick(2);

    // Stop while a 10-cycle read is outstanding
    mem_lat = 10;
    play_select = 23'h500; play_end = 23'h50F; play_start = 1'b1; reads = 0; d0 = done_cnt;
    frame(16'h1500);
    n = 0;
    while (!mif.o_mem_req && n < 20) begin tick(1); n++; end
    chk("stop_req_seen", mif.o_mem_req, 1);
    play_stop = 1'b1; tick(1); play_stop = 1'b0;
    @(negedge i_clk);
    chk("stop_req_held", mif.o_mem_req, 1); chk("stop_dac_zero", o_dac_data, 0);
    n = 0;
    while (done_cnt == d0 && n < 40) begin @(negedge i_clk); n++; end
    chk("stop_done", done_cnt - d0, 1); chk("stop_done_lat", done_cyc - req_fall_cyc, 1);
    chk("stop_reads", reads, 2); chk("stop_cur", o_cur_addr, 23'h500);
    frame(16'h0000);
    chk("stop_no_retrig", done_cnt - d0, 1);
    play_start = 1'b0; tick(2);

    // Reset mid-clip, then replay from play_select
    mem_lat = 3;
    play_select = 23'h600; play_end = 23'h60F; play_start = 1'b1;
    frame(16'h1600); frame(16'h1601);
    tick(20);
    chk("pre_rst_state", int'(dut.state), int'(STREAM));
    i_rst_n = 1'b0; play_start = 1'b0;
    tick(1);
    i_rst_n = 1'b1;
    chk("mid_rst_state", int'(dut.state), int'(IDLE)); chk("mid_rst_dac", o_dac_data, 0);
    chk("mid_rst_cur", o_cur_addr, 0); chk("mid_rst_req", mif.o_mem_req, 0);
    chk("mid_rst_done", play_done, 0);
    tick(2);
    play_start = 1'b1; reads = 0; d0 = done_cnt;
    frame(16'h1600);
    play_stop = 1'b1; tick(1); play_stop = 1'b0;
    tick(3);
    chk("replay_done", done_cnt - d0, 1); chk("replay_reads", reads, 1);
    chk("replay_cur", o_cur_addr, 23'h600);
    play_start = 1'b0; tick(2);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
